// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC owner: sequences imem req/ack, buffers fetched instructions toward ID, and arbitrates redirects.
// Define PC_SEQ_MISALIGN_CHECK_EN to report misaligned redirect targets instead of silently aligning them.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        pc_src,
  output logic [31:0] jpc,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic        br_ex,
  input  logic [31:0] br_ex_pc,
  input  logic        jmp_id,
  input  logic [31:0] jmp_id_pc,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state, next_state;
  logic        skid_valid;
  logic [31:0] skid_pc, skid_instr;
  logic [31:0] drain_pc;
  logic [1:0]  drain_prio;
  logic        redir_any, redir_ok, drain_replace;
  logic [1:0]  redir_prio;
  logic [31:0] redir_sel, redir_pc;
  logic        pc_load, flush, drain_load, cap_slot, cap_skid, slot_free;

  // Priority code: 1 = trap, 2 = EX branch, 3 = ID jal; lower number wins.
  always_comb begin
    redir_any  = trap | br_ex | jmp_id;
    redir_sel  = 32'h0;
    redir_prio = 2'd0;
    if (trap) begin
      redir_sel  = trap_pc;
      redir_prio = 2'd1;
    end else if (br_ex) begin
      redir_sel  = br_ex_pc;
      redir_prio = 2'd2;
    end else if (jmp_id) begin
      redir_sel  = jmp_id_pc;
      redir_prio = 2'd3;
    end
  end

`ifdef PC_SEQ_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = redir_any && (redir_sel[1:0] != 2'b00);
  assign redir_ok   = redir_any && !misaligned;
  assign redir_pc   = redir_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign      <= 1'b0;
      misalign_addr <= 32'h0;
    end else begin
      misalign <= misaligned;
      if (misaligned) misalign_addr <= redir_sel;
    end
  end
`else
  assign redir_ok      = redir_any;
  assign redir_pc      = redir_sel & 32'hFFFF_FFFC;
  assign misalign      = 1'b0;
  assign misalign_addr = 32'h0;
`endif

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = pc;
  assign slot_free = !if_valid || id_ready;

  always_comb begin
    next_state    = state;
    pc_src        = 1'b0;
    jpc           = 32'h0;
    pc_load       = 1'b0;
    flush         = 1'b0;
    drain_load    = 1'b0;
    cap_slot      = 1'b0;
    cap_skid      = 1'b0;
    drain_replace = redir_ok && (redir_prio <= drain_prio);
    case (state)
      IDLE: begin
        next_state = FETCH;
        if (redir_ok) begin
          pc_src  = 1'b1;
          jpc     = redir_pc;
          pc_load = 1'b1;
          flush   = 1'b1;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          pc_load = 1'b1;
          if (redir_ok) begin
            pc_src = 1'b1;
            jpc    = redir_pc;
            flush  = 1'b1;
          end else if (slot_free) begin
            cap_slot = 1'b1;
          end else begin
            cap_skid   = 1'b1;
            next_state = HOLD;
          end
        end else if (redir_ok) begin
          drain_load = 1'b1;
          flush      = 1'b1;
          next_state = DRAIN;
        end
      end
      HOLD: begin
        if (redir_ok) begin
          pc_src     = 1'b1;
          jpc        = redir_pc;
          pc_load    = 1'b1;
          flush      = 1'b1;
          next_state = FETCH;
        end else if (if_valid && id_ready) begin
          next_state = FETCH;
        end
      end
      DRAIN: begin
        // The in-flight fetch must still complete; only its data is thrown away.
        if (drain_replace) begin
          drain_load = 1'b1;
          flush      = 1'b1;
        end
        if (imem_ack) begin
          pc_src     = 1'b1;
          jpc        = drain_replace ? redir_pc : drain_pc;
          pc_load    = 1'b1;
          next_state = FETCH;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_pc   <= 32'h0;
      drain_prio <= 2'd3;
    end else begin
      state <= next_state;
      if (pc_load) pc <= npc;
      if (drain_load) begin
        drain_pc   <= redir_pc;
        drain_prio <= redir_prio;
      end
    end
  end

  // Output slot plus one-entry skid buffer; the skid refills the slot when ID consumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_instr   <= 32'h0;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
    end else if (flush) begin
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (cap_slot) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_rdata;
      end else if (if_valid && id_ready) begin
        if_valid   <= skid_valid;
        if_pc      <= skid_pc;
        if_instr   <= skid_instr;
        skid_valid <= 1'b0;
      end
      if (cap_skid) begin
        skid_valid <= 1'b1;
        skid_pc    <= pc;
        skid_instr <= imem_rdata;
      end
    end
  end

endmodule
